// File: rtl/ycr_pipe_mprf_warb.sv
// Write-port arbiter for the single MPRF write port: EXU writeback, buffered LSU load returns, HDU debug writes.
// Optional YCR_MPRF_WARB_PERF_EN adds a saturating stall-cycle counter output.
`ifndef YCR_MPRF_AWIDTH
`define YCR_MPRF_AWIDTH 5
`endif
`ifndef YCR_XLEN
`define YCR_XLEN 32
`endif

module ycr_pipe_mprf_warb #(
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int AWIDTH         = `YCR_MPRF_AWIDTH,
  parameter int DWIDTH         = `YCR_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_wr_req_i,
  input  logic [AWIDTH-1:0] exu_wr_addr_i,
  input  logic [DWIDTH-1:0] exu_wr_data_i,
  output logic              exu_wr_rdy_o,
  input  logic              lsu_wr_vld_i,
  input  logic [AWIDTH-1:0] lsu_wr_addr_i,
  input  logic [DWIDTH-1:0] lsu_wr_data_i,
  output logic              lsu_wr_rdy_o,
  input  logic              dbg_wr_vld_i,
  input  logic [AWIDTH-1:0] dbg_wr_addr_i,
  input  logic [DWIDTH-1:0] dbg_wr_data_i,
  output logic              dbg_wr_rdy_o,
  input  logic [AWIDTH-1:0] rs1_addr_i,
  input  logic [AWIDTH-1:0] rs2_addr_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic              warb2mprf_w_req_o,
  output logic [AWIDTH-1:0] warb2mprf_rd_addr_o,
  output logic [DWIDTH-1:0] warb2mprf_rd_data_o,
  output logic              warb_idle_o
`ifdef YCR_MPRF_WARB_PERF_EN
  ,
  output logic [15:0]       warb_stall_cnt_o
`endif
);

  localparam int PW = $clog2(LSU_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [AWIDTH-1:0]         fifo_addr [LSU_FIFO_DEPTH];
  logic [DWIDTH-1:0]         fifo_data [LSU_FIFO_DEPTH];
  logic [LSU_FIFO_DEPTH-1:0] fifo_kill;
  logic [LSU_FIFO_DEPTH-1:0] kill_next;
  logic [LSU_FIFO_DEPTH-1:0] occ;
  logic [PW-1:0]             slot_off [LSU_FIFO_DEPTH];
  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [CW-1:0]             count;

  logic full, empty, head_live, head_killed, head_issue, pop, push;
  logic exu_wr, dbg_wr, issue, kill_vld, kill_new;
  logic [AWIDTH-1:0] kill_addr, sel_addr;
  logic [DWIDTH-1:0] sel_data;

  assign full        = (count == CW'(LSU_FIFO_DEPTH));
  assign empty       = (count == '0);
  assign head_live   = !empty && !fifo_kill[rd_ptr];
  assign head_killed = !empty &&  fifo_kill[rd_ptr];

  // Drain mode (full FIFO with a live head) lets the head overtake EXU.
  assign exu_wr_rdy_o = !rst && exu_wr_req_i && !(full && head_live);
  assign head_issue   = !rst && head_live && (full || !exu_wr_req_i);
  assign pop          = !rst && (head_killed || head_issue);
  assign lsu_wr_rdy_o = !rst && (!full || pop);
  assign dbg_wr_rdy_o = !rst && dbg_wr_vld_i && !exu_wr_req_i && !head_live;
  assign push         = lsu_wr_vld_i && lsu_wr_rdy_o && (lsu_wr_addr_i != '0);

  assign exu_wr    = exu_wr_rdy_o && (exu_wr_addr_i != '0);
  assign dbg_wr    = dbg_wr_rdy_o && (dbg_wr_addr_i != '0);
  assign issue     = exu_wr || head_issue || dbg_wr;
  assign kill_vld  = exu_wr || dbg_wr;
  assign kill_addr = exu_wr_rdy_o ? exu_wr_addr_i : dbg_wr_addr_i;
  assign kill_new  = kill_vld && (kill_addr == lsu_wr_addr_i);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    sel_addr   = '0;
    sel_data   = '0;
    rs1_pend_o = 1'b0;
    rs2_pend_o = 1'b0;
    kill_next  = fifo_kill;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
      slot_off[i] = PW'(i) - rd_ptr;
      occ[i]      = ({1'b0, slot_off[i]} < count);
      if (occ[i] && kill_vld && (fifo_addr[i] == kill_addr)) kill_next[i] = 1'b1;
      if (occ[i] && !fifo_kill[i] && (fifo_addr[i] == rs1_addr_i)) rs1_pend_o = 1'b1;
      if (occ[i] && !fifo_kill[i] && (fifo_addr[i] == rs2_addr_i)) rs2_pend_o = 1'b1;
    end
    if (rs1_addr_i == '0) rs1_pend_o = 1'b0;
    if (rs2_addr_i == '0) rs2_pend_o = 1'b0;
    // A slot being refilled takes only the kill status of the new entry.
    if (push) kill_next[wr_ptr] = kill_new;
    if (exu_wr) begin
      sel_addr = exu_wr_addr_i;
      sel_data = exu_wr_data_i;
    end else if (head_issue) begin
      sel_addr = fifo_addr[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (dbg_wr) begin
      sel_addr = dbg_wr_addr_i;
      sel_data = dbg_wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_kill <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count     <= count + CW'(push) - CW'(pop);
      fifo_kill <= kill_next;
    end
  end

  // NOTE: payload storage is not reset; occupancy is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lsu_wr_addr_i;
      fifo_data[wr_ptr] <= lsu_wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warb2mprf_w_req_o   <= 1'b0;
      warb2mprf_rd_addr_o <= '0;
      warb2mprf_rd_data_o <= '0;
    end else begin
      warb2mprf_w_req_o <= issue;
      if (issue) begin
        warb2mprf_rd_addr_o <= sel_addr;
        warb2mprf_rd_data_o <= sel_data;
      end
    end
  end

  assign warb_idle_o = empty && !warb2mprf_w_req_o;

`ifdef YCR_MPRF_WARB_PERF_EN
  logic stall;
  assign stall = (exu_wr_req_i && !exu_wr_rdy_o) || (lsu_wr_vld_i && !lsu_wr_rdy_o);

  always_ff @(posedge clk) begin
    if (rst)                                     warb_stall_cnt_o <= '0;
    else if (stall && (warb_stall_cnt_o != '1))  warb_stall_cnt_o <= warb_stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ycr_pipe_mprf_warb.sv
// Randomized and directed bench for ycr_pipe_mprf_warb against a queue-based model of the write-port rules.
// Honours YCR_MPRF_WARB_PERF_EN when defined.
module tb_ycr_pipe_mprf_warb;

  localparam int D  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          exu_wr_req, exu_wr_rdy, lsu_wr_vld, lsu_wr_rdy, dbg_wr_vld, dbg_wr_rdy;
  logic [AW-1:0] exu_wr_addr, lsu_wr_addr, dbg_wr_addr, rs1_addr, rs2_addr, w_addr;
  logic [DW-1:0] exu_wr_data, lsu_wr_data, dbg_wr_data, w_data;
  logic          rs1_pend, rs2_pend, w_req, idle;
`ifdef YCR_MPRF_WARB_PERF_EN
  logic [15:0]   stall_cnt;
  int unsigned   exp_stall;
`endif

  always #5 clk = ~clk;

  ycr_pipe_mprf_warb #(.LSU_FIFO_DEPTH(D), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .exu_wr_req_i(exu_wr_req), .exu_wr_addr_i(exu_wr_addr), .exu_wr_data_i(exu_wr_data), .exu_wr_rdy_o(exu_wr_rdy),
    .lsu_wr_vld_i(lsu_wr_vld), .lsu_wr_addr_i(lsu_wr_addr), .lsu_wr_data_i(lsu_wr_data), .lsu_wr_rdy_o(lsu_wr_rdy),
    .dbg_wr_vld_i(dbg_wr_vld), .dbg_wr_addr_i(dbg_wr_addr), .dbg_wr_data_i(dbg_wr_data), .dbg_wr_rdy_o(dbg_wr_rdy),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_pend_o(rs1_pend), .rs2_pend_o(rs2_pend),
    .warb2mprf_w_req_o(w_req), .warb2mprf_rd_addr_o(w_addr), .warb2mprf_rd_data_o(w_data),
    .warb_idle_o(idle)
`ifdef YCR_MPRF_WARB_PERF_EN
    , .warb_stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct {
    bit er; logic [AW-1:0] ea; logic [DW-1:0] ed;
    bit lv; logic [AW-1:0] la; logic [DW-1:0] ld;
    bit dv; logic [AW-1:0] da; logic [DW-1:0] dd;
    logic [AW-1:0] r1; logic [AW-1:0] r2;
  } stim_t;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; bit k; } ent_t;

  ent_t          q[$];
  bit            exp_wreq;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit pending(input logic [AW-1:0] a);
    if (a == 0) return 0;
    foreach (q[i]) if (!q[i].k && q[i].a == a) return 1;
    return 0;
  endfunction

  task automatic step(input stim_t s);
    bit full, hl, hk, e_rdy, l_rdy, d_rdy, h_iss, pop, wr;
    logic [AW-1:0] ka;
    bit kv;
    @(negedge clk);
    rst = 1'b0;
    exu_wr_req = s.er; exu_wr_addr = s.ea; exu_wr_data = s.ed;
    lsu_wr_vld = s.lv; lsu_wr_addr = s.la; lsu_wr_data = s.ld;
    dbg_wr_vld = s.dv; dbg_wr_addr = s.da; dbg_wr_data = s.dd;
    rs1_addr = s.r1; rs2_addr = s.r2;
    #1;
    check("w_req", 64'(w_req), 64'(exp_wreq));
    check("w_addr", 64'(w_addr), 64'(exp_waddr));
    check("w_data", 64'(w_data), 64'(exp_wdata));
    check("idle", 64'(idle), 64'(q.size() == 0 && !exp_wreq));
`ifdef YCR_MPRF_WARB_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    full  = (q.size() == D);
    hl    = (q.size() > 0) && !q[0].k;
    hk    = (q.size() > 0) &&  q[0].k;
    e_rdy = s.er && !(full && hl);
    h_iss = hl && (full || !s.er);
    pop   = hk || h_iss;
    l_rdy = !full || pop;
    d_rdy = s.dv && !s.er && !hl;
    check("exu_rdy", 64'(exu_wr_rdy), 64'(e_rdy));
    check("lsu_rdy", 64'(lsu_wr_rdy), 64'(l_rdy));
    check("dbg_rdy", 64'(dbg_wr_rdy), 64'(d_rdy));
    check("rs1_pend", 64'(rs1_pend), 64'(pending(s.r1)));
    check("rs2_pend", 64'(rs2_pend), 64'(pending(s.r2)));
`ifdef YCR_MPRF_WARB_PERF_EN
    if (((s.er && !e_rdy) || (s.lv && !l_rdy)) && exp_stall != 32'hFFFF) exp_stall++;
`endif
    // Expected write for the next cycle.
    wr = 1'b1;
    if (e_rdy && s.ea != 0)      begin exp_waddr = s.ea;    exp_wdata = s.ed;    end
    else if (h_iss)              begin exp_waddr = q[0].a;  exp_wdata = q[0].d;  end
    else if (d_rdy && s.da != 0) begin exp_waddr = s.da;    exp_wdata = s.dd;    end
    else wr = 1'b0;
    exp_wreq = wr;
    // Queue update: pop, kill matching survivors, then append the new load.
    if (pop) void'(q.pop_front());
    kv = (e_rdy && s.ea != 0) || (d_rdy && s.da != 0);
    ka = e_rdy ? s.ea : s.da;
    if (kv) foreach (q[i]) if (q[i].a == ka) q[i].k = 1'b1;
    if (s.lv && l_rdy && s.la != 0) q.push_back('{a: s.la, d: s.ld, k: kv && (ka == s.la)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exu_wr_req = 1'b1; lsu_wr_vld = 1'b1; dbg_wr_vld = 1'b1;
    exu_wr_addr = 5'd3; lsu_wr_addr = 5'd4; dbg_wr_addr = 5'd6;
    #1;
    check("rst_exu_rdy", 64'(exu_wr_rdy), 64'd0);
    check("rst_lsu_rdy", 64'(lsu_wr_rdy), 64'd0);
    check("rst_dbg_rdy", 64'(dbg_wr_rdy), 64'd0);
    q.delete();
    exp_wreq = 0; exp_waddr = '0; exp_wdata = '0;
`ifdef YCR_MPRF_WARB_PERF_EN
    exp_stall = 0;
`endif
  endtask

  function automatic stim_t idle_s(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    return '{er: 0, ea: 0, ed: 0, lv: 0, la: 0, ld: 0, dv: 0, da: 0, dd: 0, r1: r1, r2: r2};
  endfunction

  function automatic stim_t rnd_s(input int pe, input int pl, input int pd);
    stim_t s;
    s.er = ($urandom_range(0, 99) < pe); s.ea = AW'($urandom_range(0, 7)); s.ed = $urandom;
    s.lv = ($urandom_range(0, 99) < pl); s.la = AW'($urandom_range(0, 7)); s.ld = $urandom;
    s.dv = ($urandom_range(0, 99) < pd); s.da = AW'($urandom_range(0, 7)); s.dd = $urandom;
    s.r1 = AW'($urandom_range(0, 7));    s.r2 = AW'($urandom_range(0, 7));
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1;
    exu_wr_req = 0; lsu_wr_vld = 0; dbg_wr_vld = 0;
    exu_wr_addr = '0; lsu_wr_addr = '0; dbg_wr_addr = '0;
    exu_wr_data = '0; lsu_wr_data = '0; dbg_wr_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // EXU x5 with empty FIFO.
    s = idle_s(5, 0); s.er = 1; s.ea = 5; s.ed = 32'h1234; step(s);
    step(idle_s(5, 0));
    // Load x7 alongside EXU x3.
    s = idle_s(7, 3); s.er = 1; s.ea = 3; s.ed = 32'h33; s.lv = 1; s.la = 7; s.ld = 32'hAA; step(s);
    repeat (3) step(idle_s(7, 3));
    // Load x9 killed by a younger EXU write to x9.
    s = idle_s(9, 0); s.er = 1; s.ea = 1; s.ed = 32'h1; s.lv = 1; s.la = 9; s.ld = 32'h11; step(s);
    s = idle_s(9, 0); s.er = 1; s.ea = 9; s.ed = 32'h22; step(s);
    repeat (3) step(idle_s(9, 0));
    // Fill the FIFO under continuous EXU traffic.
    for (int i = 0; i < 6; i++) begin
      s = idle_s(10, 11); s.er = 1; s.ea = AW'(12 + i); s.ed = 32'(i);
      s.lv = 1; s.la = AW'(10 + (i % 2)); s.ld = 32'h100 + 32'(i); step(s);
    end
    repeat (4) step(idle_s(10, 11));
    // Debug write waits for an idle port; x0 writes from every source.
    for (int i = 0; i < 4; i++) begin
      s = idle_s(2, 0); s.er = 1; s.ea = AW'(20 + i); s.ed = 32'(i); s.dv = 1; s.da = 2; s.dd = 32'hD0; step(s);
    end
    s = idle_s(2, 0); s.dv = 1; s.da = 2; s.dd = 32'hD0; step(s);
    s = idle_s(0, 0); s.er = 1; s.lv = 1; s.dv = 1; step(s);
    s = idle_s(0, 0); s.dv = 1; step(s);
    repeat (2) step(idle_s(0, 0));
    // Reset with two buffered loads.
    for (int i = 0; i < 3; i++) begin
      s = idle_s(0, 0); s.er = 1; s.ea = 1; s.ed = 32'(i); s.lv = 1; s.la = AW'(4 + i); s.ld = 32'(i); step(s);
    end
    do_reset();
    step(idle_s(4, 5));

    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 4)
        0: s = rnd_s(90, 80, 30);
        1: s = rnd_s(30, 50, 50);
        2: s = rnd_s(60, 95, 20);
        default: s = rnd_s(10, 20, 60);
      endcase
      if ($urandom_range(0, 299) == 0) do_reset();
      step(s);
    end
    repeat (4) step(idle_s(0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ycr_pipe_mprf_warb.md
Name: ycr_pipe_mprf_warb

Overview:
- Write-port arbiter/scheduler for the single MPRF write port.
- Shares the port between three requesters:
  - EXU writeback: highest priority, ALU results.
  - LSU load-return path: buffered in a small FIFO.
  - HDU debug register write.
- Keeps write ordering correct by killing stale buffered load writes.
- Exports scoreboard flags so the EXU can stall reads of registers with writes still pending.
- Sits between ycr_pipe_exu/lsu/hdu and ycr_pipe_mprf; drives the MPRF w_req/rd_addr/rd_data inputs.

Parameters:
- LSU_FIFO_DEPTH, 2, load-return buffer entries (power of two, 2..8).
- AWIDTH, `YCR_MPRF_AWIDTH, register address width.
- DWIDTH, `YCR_XLEN, register data width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- exu_wr_req_i  in  1  EXU writeback request.
- exu_wr_addr_i  in  AWIDTH  EXU rd address.
- exu_wr_data_i  in  DWIDTH  EXU rd data.
- exu_wr_rdy_o  out  1  EXU write accepted this cycle.
- lsu_wr_vld_i  in  1  load-return valid.
- lsu_wr_addr_i  in  AWIDTH  load rd address.
- lsu_wr_data_i  in  DWIDTH  load data.
- lsu_wr_rdy_o  out  1  FIFO can accept.
- dbg_wr_vld_i  in  1  debug write valid.
- dbg_wr_addr_i  in  AWIDTH  debug address.
- dbg_wr_data_i  in  DWIDTH  debug data.
- dbg_wr_rdy_o  out  1  debug write granted.
- rs1_addr_i  in  AWIDTH  EXU read address 1.
- rs2_addr_i  in  AWIDTH  EXU read address 2.
- rs1_pend_o  out  1  live FIFO entry targets rs1_addr_i.
- rs2_pend_o  out  1  live FIFO entry targets rs2_addr_i.
- warb2mprf_w_req_o  out  1  MPRF write request.
- warb2mprf_rd_addr_o  out  AWIDTH  MPRF write address.
- warb2mprf_rd_data_o  out  DWIDTH  MPRF write data.
- warb_idle_o  out  1  FIFO empty and no output write pending.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, all kill bits cleared.
  - warb2mprf_w_req_o=0; rd_addr/rd_data outputs=0.
  - Ready outputs are 0 during reset; warb_idle_o=1 after reset.
  - Reset mid-operation discards buffered load writes; no partial write is issued.
- Latency: the selected write appears on the warb2mprf_* registers one cycle after acceptance. Exactly one write per cycle.
- x0 handling: a write with addr==0 is accepted (rdy=1), never enqueued, never issued.
- LSU FIFO:
  - Enqueue when lsu_wr_vld_i && lsu_wr_rdy_o.
  - lsu_wr_rdy_o = !full || pop this cycle.
  - Pointers wrap modulo LSU_FIFO_DEPTH; count is AWIDTH-independent, log2(DEPTH)+1 bits.
- Arbitration, evaluated combinationally each cycle:
  - Normal mode (FIFO not full): EXU > FIFO head > DBG.
  - Drain mode (FIFO full): FIFO head > EXU > DBG; exu_wr_rdy_o=0 while head wins.
  - Debug is granted only when neither EXU nor a live FIFO head requests.
  - A killed FIFO head is popped without issuing a write and does not consume the port that cycle.
- Ordering/kill:
  - An accepted EXU write to addr A sets the kill bit of every live FIFO entry with addr A, including an entry enqueued in the same cycle.
  - An accepted debug write does the same.
- Scoreboard: rsN_pend_o=1 iff any live (non-killed) FIFO entry has addr==rsN_addr_i and rsN_addr_i!=0. Purely combinational from FIFO state.
- Simultaneous enqueue and pop on a full FIFO is allowed; count is unchanged.
- Empty FIFO: no issue from it; an LSU enqueue is issued no earlier than the next cycle.

Optional Feature:
- Macro: YCR_MPRF_WARB_PERF_EN.
- With it defined:
  - Extra output warb_stall_cnt_o [15:0], counting cycles where (exu_wr_req_i && !exu_wr_rdy_o) || (lsu_wr_vld_i && !lsu_wr_rdy_o).
  - Saturates at 16'hFFFF; cleared by rst.
- Without it: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- EXU write x5=32'h1234 with FIFO empty -> next cycle w_req=1, addr=5, data=32'h1234; exu_wr_rdy_o=1 in the request cycle.
- LSU load x7=32'hAA while EXU writes x3 in the same cycle -> x3 issued at cycle+1, x7 at cycle+2; rs1_addr=7 shows rs1_pend_o=1 until x7 is popped.
- LSU enqueues x9=32'h11, then EXU writes x9=32'h22 before the drain -> only 32'h22 reaches the MPRF; the killed entry pops silently; rs1_pend_o(9)=0 after the kill.
- Fill FIFO (DEPTH=2) while EXU requests every cycle -> exu_wr_rdy_o=0 and FIFO head issued each cycle until not full; lsu_wr_rdy_o=0 while full with no pop.
- Debug write x2 with continuous EXU traffic -> dbg_wr_rdy_o stays 0; grant occurs in the first idle cycle; x0 writes from any source produce no w_req.
- Assert rst with 2 entries buffered -> FIFO empty, w_req=0, warb_idle_o=1 next cycle; with PERF_EN the counter reads 0.
